// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      PAUSE,
      SET_MIN,
      SET_SEC
   } sw_state_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_MIN  = 2'b01;
   localparam logic [1:0] SEL_SEC  = 2'b10;

endpackage

// File: rtl/btn_cond.sv
// Push-button conditioner: 2-FF synchronizer, stability-count debouncer and
// rising-edge detector producing a single-cycle event per accepted press.
module btn_cond #(
   parameter int unsigned DEB_LEN = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int unsigned CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_LEN - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          prev_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         cnt_q   <= cnt_d;
      end
   end

   // Accept the new level on the DEB_LEN-th consecutive differing sample.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign level = level_q;
   assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button conditioning, 1 Hz prescaler and the
// run/pause/set FSM driving CEN/INC/CLR of the seconds and minutes counters.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned DEB_LEN  = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_set,
   input  logic       btn_inc,
   input  logic       btn_clr,
   input  logic       sec_ca,
   output logic       cen_sec,
   output logic       cen_min,
   output logic       inc_sec,
   output logic       inc_min,
   output logic       clr_cnt,
   output logic       running,
   output logic [1:0] set_sel
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic [3:0] btn_raw, btn_lvl, btn_rise;
   logic       start_ev, set_ev, inc_ev, clr_ev;

   assign btn_raw = {btn_clr, btn_inc, btn_set, btn_start};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_cond #(
         .DEB_LEN (DEB_LEN)
      ) u_btn_cond (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[i]),
         .level (btn_lvl[i]),
         .rise  (btn_rise[i])
      );
   end

   assign start_ev = btn_rise[0] & btn_lvl[0];
   assign set_ev   = btn_rise[1] & btn_lvl[1];
   assign inc_ev   = btn_rise[2] & btn_lvl[2];
   assign clr_ev   = btn_rise[3] & btn_lvl[3];

   sw_state_t     state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          inc_min_q, inc_min_d;
   logic          inc_sec_q, inc_sec_d;
   logic          clr_q, clr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         inc_min_q <= 1'b0;
         inc_sec_q <= 1'b0;
         clr_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         inc_min_q <= inc_min_d;
         inc_sec_q <= inc_sec_d;
         clr_q     <= clr_d;
      end
   end

   // Prescaler only advances in RUN; PAUSE/SET keep the partial second.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      inc_min_d = 1'b0;
      inc_sec_d = 1'b0;
      clr_d     = 1'b0;

      if (state_q == RUN) begin
         presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      end

      if (clr_ev) begin
         state_d = IDLE;
         presc_d = '0;
         clr_d   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE, PAUSE: begin
               if (start_ev)    state_d = RUN;
               else if (set_ev) state_d = SET_MIN;
            end
            RUN: begin
               if (start_ev) state_d = PAUSE;
            end
            SET_MIN: begin
               if (set_ev)      state_d   = SET_SEC;
               else if (inc_ev) inc_min_d = 1'b1;
            end
            SET_SEC: begin
               if (set_ev)      state_d   = PAUSE;
               else if (inc_ev) inc_sec_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      set_sel = SEL_NONE;
      if (state_q == SET_MIN)      set_sel = SEL_MIN;
      else if (state_q == SET_SEC) set_sel = SEL_SEC;
   end

   assign running = (state_q == RUN);
   assign cen_sec = running & (presc_q == PRESC_MAX);
   assign cen_min = sec_ca & running;
   assign inc_min = inc_min_q;
   assign inc_sec = inc_sec_q;
   assign clr_cnt = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV=4, DEB_LEN=3.
module tb_stopwatch_ctrl;

   logic       clk;
   logic       rst;
   logic       btn_start, btn_set, btn_inc, btn_clr;
   logic       sec_ca;
   logic       cen_sec, cen_min, inc_sec, inc_min, clr_cnt, running;
   logic [1:0] set_sel;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Per-press observation window results (sample index 1..12, 0 = never seen).
   int n_im, n_is, n_clr, n_cen;
   int f_im, f_is, f_clr, f_cen, f_run;
   int cnt;

   stopwatch_ctrl #(
      .TICK_DIV (4),
      .DEB_LEN  (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_set   (btn_set),
      .btn_inc   (btn_inc),
      .btn_clr   (btn_clr),
      .sec_ca    (sec_ca),
      .cen_sec   (cen_sec),
      .cen_min   (cen_min),
      .inc_sec   (inc_sec),
      .inc_min   (inc_min),
      .clr_cnt   (clr_cnt),
      .running   (running),
      .set_sel   (set_sel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hold the masked buttons {clr,inc,set,start} for 6 cycles, release, and
   // record pulses over 12 samples. The event lands on sample 6.
   task automatic press(input logic [3:0] m);
      n_im = 0; n_is = 0; n_clr = 0; n_cen = 0;
      f_im = 0; f_is = 0; f_clr = 0; f_cen = 0; f_run = 0;
      {btn_clr, btn_inc, btn_set, btn_start} = m;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (inc_min) begin n_im++;  if (f_im == 0)  f_im = i;  end
         if (inc_sec) begin n_is++;  if (f_is == 0)  f_is = i;  end
         if (clr_cnt) begin n_clr++; if (f_clr == 0) f_clr = i; end
         if (cen_sec) begin n_cen++; if (f_cen == 0) f_cen = i; end
         if (running && f_run == 0) f_run = i;
         if (i == 6) {btn_clr, btn_inc, btn_set, btn_start} = 4'b0000;
      end
   endtask

   initial begin
      rst = 1'b1;
      {btn_clr, btn_inc, btn_set, btn_start} = 4'b0000;
      sec_ca = 1'b0;

      // 1. Reset held two cycles
      step(1);
      check("rst_clr_c1", clr_cnt, 1);
      check("rst_run_c1", running, 0);
      step(1);
      check("rst_clr_c2", clr_cnt, 1);
      check("rst_sel_c2", set_sel, 0);
      rst = 1'b0;
      step(1);
      check("idle_clr", clr_cnt, 0);
      check("idle_run", running, 0);
      check("idle_sel", set_sel, 0);
      check("idle_inc", {inc_min, inc_sec}, 0);
      check("idle_cen", cen_sec, 0);
      sec_ca = 1'b1;
      #1;
      check("idle_cenmin", cen_min, 0);
      sec_ca = 1'b0;

      // 2. Start from IDLE: RUN at sample 6, first tick 4 cycles later (sample 9)
      press(4'b0001);
      check("start_run_lat", f_run, 6);
      check("start_first_cen", f_cen, 9);
      check("start_cen_cnt", n_cen, 1);
      step(1);
      check("tick2_cen", cen_sec, 1);
      sec_ca = 1'b1;
      #1;
      check("run_cenmin", cen_min, 1);
      sec_ca = 1'b0;
      #1;
      check("run_cenmin_off", cen_min, 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (cen_sec) cnt++;
      end
      check("run_cen_8cyc", cnt, 2);

      // 3. Pause with prescaler at 2, then resume: tick on first RUN cycle
      step(2);
      press(4'b0001);
      check("pause_run", running, 0);
      check("pause_cen_before", f_cen, 2);
      check("pause_cen_cnt", n_cen, 1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (cen_sec) cnt++;
      end
      check("pause_no_cen", cnt, 0);
      sec_ca = 1'b1;
      #1;
      check("pause_cenmin", cen_min, 0);
      sec_ca = 1'b0;
      press(4'b0001);
      check("resume_run_lat", f_run, 6);
      check("resume_cen_first", f_cen, 6);
      check("resume_cen_cnt", n_cen, 2);
      press(4'b0001);
      check("pause2_run", running, 0);

      // 4. set, inc, inc, set, inc, set from PAUSE
      press(4'b0010);
      check("setmin_sel", set_sel, 1);
      check("setmin_run", running, 0);
      press(4'b0100);
      check("inc1_min_cnt", n_im, 1);
      check("inc1_min_at", f_im, 6);
      check("inc1_sec_cnt", n_is, 0);
      press(4'b0100);
      check("inc2_min_cnt", n_im, 1);
      press(4'b0010);
      check("setsec_sel", set_sel, 2);
      sec_ca = 1'b1;
      #1;
      check("setsec_cenmin", cen_min, 0);
      sec_ca = 1'b0;
      press(4'b0100);
      check("inc3_sec_cnt", n_is, 1);
      check("inc3_sec_at", f_is, 6);
      check("inc3_min_cnt", n_im, 0);
      check("inc3_cen_cnt", n_cen, 0);
      press(4'b0010);
      check("setdone_sel", set_sel, 0);
      check("setdone_run", running, 0);
      press(4'b0001);
      check("setdone_resume", running, 1);

      // 5. clr and start together in RUN: clr wins
      press(4'b1001);
      check("clr_run", running, 0);
      check("clr_pulse_cnt", n_clr, 1);
      check("clr_pulse_at", f_clr, 6);
      check("clr_sel", set_sel, 0);
      press(4'b0001);
      check("clr_restart_run", f_run, 6);
      check("clr_presc_zero", f_cen, 9);

      // 6. Glitch and long hold on btn_inc in SET_MIN
      press(4'b0001);
      press(4'b0010);
      check("g_setmin_sel", set_sel, 1);
      press(4'b0001);
      check("g_start_ignored", set_sel, 1);
      check("g_start_norun", running, 0);
      btn_inc = 1'b1;
      step(2);
      btn_inc = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (inc_min) cnt++;
      end
      check("glitch_no_inc", cnt, 0);
      btn_inc = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (inc_min) cnt++;
      end
      btn_inc = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (inc_min) cnt++;
      end
      check("hold_one_inc", cnt, 1);

      // Reset in the middle of SET_MIN
      rst = 1'b1;
      step(1);
      check("midrst_clr", clr_cnt, 1);
      check("midrst_sel", set_sel, 0);
      rst = 1'b0;
      step(1);
      check("midrst_clr_off", clr_cnt, 0);
      check("midrst_run", running, 0);
      press(4'b0001);
      check("midrst_restart", f_run, 6);
      check("midrst_presc", f_cen, 9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
